// File: rtl/irq_priority_ctrl.sv
// Six-line prioritized interrupt controller: edge-captured requests, software mask,
// nested in-service tracking and vectored acknowledge toward the CPU.
module irq_priority_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'h20,
    parameter logic [7:0] SPUR_OFS = 8'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] irq,
    input  logic       imr_we,
    input  logic [5:0] imr_din,
    input  logic       inta,
    input  logic       eoi,
    output logic       int_req,
    output logic [7:0] vector,
    output logic       vec_valid,
    output logic [5:0] irr_o,
    output logic [5:0] isr_o,
    output logic [5:0] imr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Index of the highest-priority (lowest-index) set bit; 0 when none is set.
    function automatic logic [2:0] prio_idx(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_t     state_r, state_nx_s;
    logic [5:0] irq_d_r, irr_r, isr_r, imr_r;
    logic [7:0] vector_r;
    logic       int_req_r, vec_valid_r;

    logic [5:0] edge_s, pending_s, isr_eoi_s, grant_mask_s;
    logic [2:0] top_pend_s, top_isr_s, top_isr_eoi_s;
    logic       elig_cur_s, elig_ack_s, grant_s, spur_s;

    // Pending/in-service priority resolution; the ack compare sees isr after eoi retirement.
    always_comb begin
        edge_s        = irq & ~irq_d_r;
        pending_s     = irr_r & ~imr_r;
        top_pend_s    = prio_idx(pending_s);
        top_isr_s     = prio_idx(isr_r);
        if (eoi && (isr_r != 6'd0)) begin
            isr_eoi_s = isr_r & ~(6'b000001 << top_isr_s);
        end else begin
            isr_eoi_s = isr_r;
        end
        top_isr_eoi_s = prio_idx(isr_eoi_s);
        elig_cur_s    = (pending_s != 6'd0) &&
                        ((isr_r == 6'd0) || (top_pend_s < top_isr_s));
        elig_ack_s    = (pending_s != 6'd0) &&
                        ((isr_eoi_s == 6'd0) || (top_pend_s < top_isr_eoi_s));
    end

    // Next-state and acknowledge decisions.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        spur_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (elig_cur_s) begin
                    state_nx_s = REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (inta) begin
                    grant_s    = elig_ack_s;
                    spur_s     = ~elig_ack_s;
                    state_nx_s = ACK;
                end else if (!elig_cur_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = REQ;
                end
            end
            ACK:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
        if (grant_s) begin
            grant_mask_s = 6'b000001 << top_pend_s;
        end else begin
            grant_mask_s = 6'd0;
        end
    end

    // State, request/service/mask registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            irq_d_r     <= 6'd0;
            irr_r       <= 6'd0;
            isr_r       <= 6'd0;
            imr_r       <= 6'b111111;
            vector_r    <= 8'd0;
            int_req_r   <= 1'b0;
            vec_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            irq_d_r     <= irq;
            // A fresh edge on the line being acked re-pends it.
            irr_r       <= (irr_r & ~grant_mask_s) | edge_s;
            isr_r       <= isr_eoi_s | grant_mask_s;
            imr_r       <= imr_we ? imr_din : imr_r;
            if (grant_s) begin
                vector_r <= VEC_BASE + {5'd0, top_pend_s};
            end else if (spur_s) begin
                vector_r <= VEC_BASE + SPUR_OFS;
            end else begin
                vector_r <= vector_r;
            end
            int_req_r   <= (state_nx_s == REQ);
            vec_valid_r <= (state_nx_s == ACK);
        end
    end

    assign int_req   = int_req_r;
    assign vector    = vector_r;
    assign vec_valid = vec_valid_r;
    assign irr_o     = irr_r;
    assign isr_o     = isr_r;
    assign imr_o     = imr_r;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scenario bench for irq_priority_ctrl; acknowledged vectors are checked through a
// scoreboard queue filled when inta is driven and drained on each vec_valid strobe.
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq;
    logic       imr_we;
    logic [5:0] imr_din;
    logic       inta;
    logic       eoi;
    logic       int_req;
    logic [7:0] vector;
    logic       vec_valid;
    logic [5:0] irr_o, isr_o, imr_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    irq_priority_ctrl dut (
        .clk(clk), .reset(reset), .irq(irq), .imr_we(imr_we), .imr_din(imr_din),
        .inta(inta), .eoi(eoi), .int_req(int_req), .vector(vector),
        .vec_valid(vec_valid), .irr_o(irr_o), .isr_o(isr_o), .imr_o(imr_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every vec_valid strobe must match the oldest expected vector.
    always @(negedge clk) begin
        if (!reset && vec_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got vector %h with no expected entry", vector);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (vector !== e) begin
                    n_fail++;
                    $display("FAIL sb_vector: got %h want %h", vector, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_imr(input logic [5:0] v);
        imr_we = 1'b1; imr_din = v;
        tick();
        imr_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; irq = 6'd0; imr_we = 1'b0; imr_din = 6'd0; inta = 1'b0; eoi = 1'b0;
        tick(2);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_int_req: got %b want 0", int_req); end
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vec_valid: got %b want 0", vec_valid); end
        n_checks++; if (vector !== 8'h00) begin n_fail++; $display("FAIL rst_vector: got %h want 00", vector); end
        n_checks++; if ({irr_o, isr_o} !== 12'd0) begin n_fail++; $display("FAIL rst_irr_isr: got %b %b want 0 0", irr_o, isr_o); end
        n_checks++; if (imr_o !== 6'b111111) begin n_fail++; $display("FAIL rst_imr: got %b want 111111", imr_o); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        write_imr(6'd0);
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        n_checks++; if (irr_o !== 6'b001000) begin n_fail++; $display("FAIL basic_irr: got %b want 001000", irr_o); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got %b want 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: got %b want 1", int_req); end
        exp_q.push_back(8'h23); inta = 1'b1;
        tick();
        inta = 1'b0;
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL basic_vv_hi: got %b want 1", vec_valid); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_int_low: got %b want 0", int_req); end
        n_checks++; if (isr_o !== 6'b001000 || irr_o !== 6'd0) begin n_fail++; $display("FAIL basic_isr_irr: got %b %b want 001000 000000", isr_o, irr_o); end
        tick();
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL basic_vv_lo: got %b want 0", vec_valid); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'd0) begin n_fail++; $display("FAIL basic_eoi: got %b want 000000", isr_o); end
    endtask

    task automatic test_two_lines;
        irq = 6'b010010;
        tick();
        irq = 6'd0;
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL two_req1: got %b want 1", int_req); end
        exp_q.push_back(8'h21); inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (isr_o !== 6'b000010 || irr_o !== 6'b010000) begin n_fail++; $display("FAIL two_after_ack1: got %b %b want 000010 010000", isr_o, irr_o); end
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'd0 || int_req !== 1'b0) begin n_fail++; $display("FAIL two_eoi1: got isr %b req %b want 000000 0", isr_o, int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL two_req2: got %b want 1", int_req); end
        exp_q.push_back(8'h24); inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (isr_o !== 6'b010000) begin n_fail++; $display("FAIL two_isr2: got %b want 010000", isr_o); end
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'd0) begin n_fail++; $display("FAIL two_eoi2: got %b want 000000", isr_o); end
    endtask

    task automatic test_nesting;
        irq[2] = 1'b1; tick(); irq[2] = 1'b0; tick();
        exp_q.push_back(8'h22); inta = 1'b1; tick(); inta = 1'b0; tick();
        irq[0] = 1'b1; tick(); irq[0] = 1'b0; tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_req: got %b want 1", int_req); end
        exp_q.push_back(8'h20); inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (isr_o !== 6'b000101) begin n_fail++; $display("FAIL nest_isr: got %b want 000101", isr_o); end
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'b000100) begin n_fail++; $display("FAIL nest_eoi1: got %b want 000100", isr_o); end
        irq[5] = 1'b1; tick(); irq[5] = 1'b0; tick(2);
        n_checks++; if (int_req !== 1'b0 || irr_o !== 6'b100000) begin n_fail++; $display("FAIL nest_blocked: got req %b irr %b want 0 100000", int_req, irr_o); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'd0 || int_req !== 1'b0) begin n_fail++; $display("FAIL nest_eoi2: got isr %b req %b want 000000 0", isr_o, int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_req5: got %b want 1", int_req); end
        exp_q.push_back(8'h25); inta = 1'b1; tick(); inta = 1'b0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_masking;
        write_imr(6'b000010);
        irq[1] = 1'b1; tick(); irq[1] = 1'b0;
        n_checks++; if (irr_o[1] !== 1'b1) begin n_fail++; $display("FAIL mask_irr: got %b want 1", irr_o[1]); end
        tick(2);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_noreq: got %b want 0", int_req); end
        write_imr(6'd0);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_n: got %b want 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL mask_unmask_n1: got %b want 1", int_req); end
        write_imr(6'b000010);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL mask_hold: got %b want 1", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b0 || irr_o !== 6'b000010) begin n_fail++; $display("FAIL mask_retract: got req %b irr %b want 0 000010", int_req, irr_o); end
    endtask

    task automatic test_spurious;
        write_imr(6'd0);
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL spur_req: got %b want 1", int_req); end
        write_imr(6'b000010);
        exp_q.push_back(8'h27); inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (isr_o !== 6'd0 || irr_o !== 6'b000010 || vec_valid !== 1'b1) begin n_fail++; $display("FAIL spur_state: got isr %b irr %b vv %b want 000000 000010 1", isr_o, irr_o, vec_valid); end
        tick();
        write_imr(6'd0);
        tick();
        exp_q.push_back(8'h21); inta = 1'b1; tick(); inta = 1'b0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr_o !== 6'd0 || irr_o !== 6'd0) begin n_fail++; $display("FAIL spur_cleanup: got %b %b want 0 0", isr_o, irr_o); end
    endtask

    task automatic test_simultaneous;
        irq[3] = 1'b1; tick(); irq[3] = 1'b0; tick();
        exp_q.push_back(8'h23); inta = 1'b1; tick(); inta = 1'b0; tick();
        irq[3] = 1'b1; tick(); irq[3] = 1'b0; tick(2);
        n_checks++; if (int_req !== 1'b0 || irr_o !== 6'b001000) begin n_fail++; $display("FAIL sim_equal_prio: got req %b irr %b want 0 001000", int_req, irr_o); end
        // Line 1 raises REQ, then gets masked so only the line-3 request remains for the ack.
        irq[1] = 1'b1; tick(); irq[1] = 1'b0; tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL sim_req1: got %b want 1", int_req); end
        write_imr(6'b000010);
        exp_q.push_back(8'h23); inta = 1'b1; eoi = 1'b1; tick(); inta = 1'b0; eoi = 1'b0;
        n_checks++; if (isr_o !== 6'b001000 || irr_o !== 6'b000010) begin n_fail++; $display("FAIL sim_eoi_inta: got isr %b irr %b want 001000 000010", isr_o, irr_o); end
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        write_imr(6'd0);
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL sim_req2: got %b want 1", int_req); end
        exp_q.push_back(8'h21); inta = 1'b1; irq[1] = 1'b1; tick(); inta = 1'b0; irq[1] = 1'b0;
        n_checks++; if (irr_o !== 6'b000010 || isr_o !== 6'b000010) begin n_fail++; $display("FAIL sim_repend: got irr %b isr %b want 000010 000010", irr_o, isr_o); end
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL sim_req3: got %b want 1", int_req); end
        reset = 1'b1;
        #1;
        n_checks++; if (int_req !== 1'b0 || vec_valid !== 1'b0 || vector !== 8'h00) begin n_fail++; $display("FAIL sim_reset_out: got req %b vv %b vec %h want 0 0 00", int_req, vec_valid, vector); end
        n_checks++; if (irr_o !== 6'd0 || isr_o !== 6'd0 || imr_o !== 6'b111111) begin n_fail++; $display("FAIL sim_reset_regs: got %b %b %b want 000000 000000 111111", irr_o, isr_o, imr_o); end
        tick();
        reset = 1'b0;
        tick(2);
        n_checks++; if (int_req !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL sim_post_reset: got req %b queue %0d want 0 0", int_req, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_lines();
        test_nesting();
        test_masking();
        test_spurious();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
